// File: rtl/ahb_sram_slave.sv
// AHB (AMBA 2) single-port SRAM slave with programmable wait states, lane writes,
// two-cycle ERROR response and write-to-read forwarding on the same word.
module ahb_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_e;

  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] off);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return ~off[0];
      3'd2:    return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          size_q, size_d;
  logic                write_q, write_d;
  logic [31:0]         hrdata_q, hrdata_d;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                accept;
  logic                commit;
  logic [3:0]          byte_en;
  logic [31:0]         merged;
  logic                rd_load;
  logic [ADDR_W-1:0]   rd_idx;
  logic [31:0]         rd_word;

  logic unused_bits;
  assign unused_bits = &{1'b0, haddr[31:ADDR_W+2], htrans[0]};

  assign accept = hsel & htrans[1] & hready;
  assign commit = (state_q == S_LAST) & write_q;

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << off_q;
      3'd1:    byte_en = 4'b0011 << off_q;
      default: byte_en = 4'b1111;
    endcase
    merged = mem_q[idx_q];
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) merged[b*8 +: 8] = hwdata[b*8 +: 8];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    rd_load = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      S_IDLE, S_LAST, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          idx_d   = haddr[ADDR_W+1:2];
          off_d   = haddr[1:0];
          size_d  = hsize;
          write_d = hwrite;
          if (!is_legal(hsize, haddr[1:0])) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_LAST;
            rd_load = ~hwrite;
            rd_idx  = haddr[ADDR_W+1:2];
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_LAST;
          rd_load = ~write_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // A read entering LAST on the edge a write to the same word commits sees the merged word.
  assign rd_word  = (commit && (idx_q == rd_idx)) ? merged : mem_q[rd_idx];
  assign hrdata_d = rd_load ? rd_word : hrdata_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      idx_q    <= '0;
      off_q    <= 2'b00;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      hrdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  end

  // NOTE: the memory array has no reset; contents survive hreset_n and a reset
  // edge only suppresses a pending commit.
  always_ff @(posedge hclk) begin
    if (hreset_n && commit) mem_q[idx_q] <= merged;
  end

  assign hrdata    = hrdata_q;
  assign hreadyout = ~((state_q == S_WAIT) || (state_q == S_ERR1));
  assign hresp     = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: three instances (0, 1 and 3 wait states) on a shared bus,
// directed scenarios then randomized transfers against a byte-level memory model.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        stall;
  int          cur;

  logic [31:0] hrd [3];
  logic        hro [3];
  logic [1:0]  hrs [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m   [3][1024];
  logic [31:0] last_rd [3];

  always #5 hclk = ~hclk;

  assign hready = stall ? 1'b0 : hro[cur];

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel_v[0]), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hrdata(hrd[0]), .hreadyout(hro[0]), .hresp(hrs[0]));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) u_ws1 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel_v[1]), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hrdata(hrd[1]), .hreadyout(hro[1]), .hresp(hrs[1]));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel_v[2]), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hrdata(hrd[2]), .hreadyout(hro[2]), .hresp(hrs[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  // Reference rule: a transfer of 2**size bytes is legal when it fits naturally aligned in a word.
  function automatic bit legal_m(input int size, input int off);
    if (size > 2) return 0;
    return (off % (1 << size)) == 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic bus_idle;
    hsel_v = '0;
    htrans = 2'b00;
  endtask

  // Single non-pipelined transfer; entered and left at #1 after a rising edge.
  task automatic xfer(input int d, input logic [31:0] addr, input bit wr,
                      input int size, input logic [31:0] wdata, input string tag);
    int  idx  = int'(addr[11:2]);
    int  off  = int'(addr[1:0]);
    bit  ok   = legal_m(size, off);
    int  expw = ok ? ws_of(d) : 1;
    int  waits = 0;
    logic [1:0] first_resp = 2'b00;
    cur       = d;
    hsel_v    = '0;
    hsel_v[d] = 1'b1;
    htrans    = 2'b10;
    haddr     = addr;
    hwrite    = wr;
    hsize     = 3'(size);
    tick();
    bus_idle();
    hwdata = wdata;
    while (hro[d] !== 1'b1 && waits < 20) begin
      if (waits == 0) first_resp = hrs[d];
      waits++;
      tick();
    end
    check($sformatf("%s_waits", tag), 32'(waits), 32'(expw));
    if (expw > 0) check($sformatf("%s_resp_stall", tag), 32'(first_resp), ok ? 32'd0 : 32'd1);
    check($sformatf("%s_resp_done", tag), 32'(hrs[d]), ok ? 32'd0 : 32'd1);
    if (ok && wr) begin
      for (int b = 0; b < 4; b++)
        if (b >= off && b < off + (1 << size)) mem_m[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
    end
    if (ok && !wr) last_rd[d] = mem_m[d][idx];
    check($sformatf("%s_hrdata", tag), hrd[d], last_rd[d]);
    tick();
  endtask

  initial begin
    logic [31:0] a;
    bit          w;
    int          s;
    stall    = 1'b0;
    cur      = 0;
    hreset_n = 1'b0;
    hsel_v   = '0;
    haddr    = '0;
    hwrite   = 1'b0;
    hsize    = 3'd0;
    htrans   = 2'b00;
    hwdata   = '0;
    for (int d = 0; d < 3; d++) last_rd[d] = 32'd0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_ready%0d", d), 32'(hro[d]), 32'd1);
      check($sformatf("rst_resp%0d", d), 32'(hrs[d]), 32'd0);
      check($sformatf("rst_hrdata%0d", d), hrd[d], 32'd0);
    end
    hreset_n = 1'b1;
    tick();

    // One wait state: word write then read back.
    xfer(1, 32'h10, 1, 2, 32'hDEADBEEF, "ws1_wr");
    xfer(1, 32'h10, 0, 2, 32'h0, "ws1_rd");
    check("ws1_rd_value", hrd[1], 32'hDEADBEEF);

    // Lane writes into a preset word.
    xfer(1, 32'h20, 1, 2, 32'h11223344, "lane_preset");
    xfer(1, 32'h21, 1, 0, 32'h0000AA00, "lane_byte");
    xfer(1, 32'h22, 1, 1, 32'h55660000, "lane_half");
    xfer(1, 32'h20, 0, 2, 32'h0, "lane_rd");
    check("lane_value", hrd[1], 32'h5566AA44);

    // Zero wait states: write followed back-to-back by a read of the same word.
    cur = 0;
    hsel_v = 3'b001; htrans = 2'b10; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2;
    tick();
    check("b2b_wr_ready", 32'(hro[0]), 32'd1);
    hwrite = 1'b0; hwdata = 32'hCAFEF00D;
    tick();
    bus_idle();
    mem_m[0][16] = 32'hCAFEF00D;
    last_rd[0]   = 32'hCAFEF00D;
    check("b2b_rd_ready", 32'(hro[0]), 32'd1);
    check("b2b_rd_resp", 32'(hrs[0]), 32'd0);
    check("b2b_fwd_data", hrd[0], 32'hCAFEF00D);
    tick();

    // Illegal accesses.
    xfer(0, 32'h43, 0, 1, 32'h0, "err_half");
    xfer(0, 32'h41, 1, 2, 32'h0, "err_word");
    xfer(0, 32'h40, 0, 2, 32'h0, "err_after");
    check("err_mem_kept", hrd[0], 32'hCAFEF00D);

    // Reset during the second wait cycle of a three-wait-state read.
    xfer(2, 32'h80, 1, 2, 32'h0BADCAFE, "rst_pre_wr");
    xfer(2, 32'h80, 0, 2, 32'h0, "rst_pre_rd");
    cur = 2;
    hsel_v = 3'b100; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b0; hsize = 3'd2;
    tick();
    bus_idle();
    check("rst_mid_wait1", 32'(hro[2]), 32'd0);
    tick();
    check("rst_mid_wait2", 32'(hro[2]), 32'd0);
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    for (int d = 0; d < 3; d++) last_rd[d] = 32'd0;
    check("rst_abort_ready", 32'(hro[2]), 32'd1);
    check("rst_abort_resp", 32'(hrs[2]), 32'd0);
    check("rst_abort_hrdata", hrd[2], 32'd0);
    tick();
    xfer(2, 32'h80, 0, 2, 32'h0, "rst_post_rd");
    check("rst_mem_kept", hrd[2], 32'h0BADCAFE);

    // Selected IDLE transfers and a NONSEQ write while another slave stalls.
    cur = 1;
    hsel_v = 3'b010; htrans = 2'b00; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
    hwdata = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("idle_ready%0d", i), 32'(hro[1]), 32'd1);
      check($sformatf("idle_resp%0d", i), 32'(hrs[1]), 32'd0);
    end
    stall = 1'b1; htrans = 2'b10;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("stall_ready%0d", i), 32'(hro[1]), 32'd1);
      check($sformatf("stall_resp%0d", i), 32'(hrs[1]), 32'd0);
    end
    bus_idle();
    stall = 1'b0;
    tick();
    xfer(1, 32'h10, 0, 2, 32'h0, "stall_rd");
    check("stall_no_write", hrd[1], 32'hDEADBEEF);

    // Randomized transfers over a preset window, with aliased upper address bits.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++)
        xfer(d, 32'h100 + 32'(k * 4), 1, 2, $urandom, $sformatf("rnd_init%0d_%0d", d, k));
      for (int n = 0; n < 30; n++) begin
        a = 32'h100 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3))
            + ({20'($urandom), 12'h000});
        w = 1'($urandom_range(0, 1));
        s = int'($urandom_range(0, 4));
        xfer(d, a, w, s, $urandom, $sformatf("rnd%0d_%0d", d, n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
